// File: rtl/mul_ctrl_if.sv
// Request, response and multiplier-side signals of the multiply controller.
// slave: the controller; master: the requester/multiplier side.
interface mul_ctrl_if #(
   parameter int XLEN = 32,
   parameter int TAGW = 5
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        op;
   logic [XLEN-1:0]   rs1;
   logic [XLEN-1:0]   rs2;
   logic [TAGW-1:0]   rd_tag;
   logic              flush;
   logic              res_valid;
   logic              res_ready;
   logic [XLEN-1:0]   result;
   logic [TAGW-1:0]   res_tag;
   logic              mul_start;
   logic              mul_x_signed;
   logic              mul_y_signed;
   logic [XLEN-1:0]   mul_x;
   logic [XLEN-1:0]   mul_y;
   logic              mul_valid;
   logic [2*XLEN-1:0] mul_z;

   modport slave (
      input  req_valid, op, rs1, rs2, rd_tag, flush, res_ready, mul_valid, mul_z,
      output req_ready, res_valid, result, res_tag,
             mul_start, mul_x_signed, mul_y_signed, mul_x, mul_y
   );

   modport master (
      output req_valid, op, rs1, rs2, rd_tag, flush, res_ready, mul_valid, mul_z,
      input  req_ready, res_valid, result, res_tag,
             mul_start, mul_x_signed, mul_y_signed, mul_x, mul_y
   );
endinterface

// File: rtl/mul_ctrl.sv
// Sequencer between the issue stage and an external variable-latency multiplier.
// Optional MUL_FUSION_EN keeps the last completed product to answer repeated operand pairs.
package core_config_pkg;
   localparam int XLEN = 32;
endpackage

// state | meaning
// IDLE  | ready for a new request
// BUSY  | multiplier started, waiting for mul_valid
// DRAIN | flushed while busy, discarding the pending product
// DONE  | result presented, waiting for res_ready
module mul_ctrl #(
   parameter int XLEN = core_config_pkg::XLEN,
   parameter int TAGW = 5
) (
   input logic        clk,
   input logic        rst_n,
   mul_ctrl_if.slave  bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam logic [1:0] OP_MUL = 2'b00;

   logic [1:0]        state;
   logic [1:0]        op_q;
   logic [XLEN-1:0]   x_q;
   logic [XLEN-1:0]   y_q;
   logic [TAGW-1:0]   tag_q;
   logic              xs_q;
   logic              ys_q;
   logic              start_q;
   logic [XLEN-1:0]   result_q;
   logic              accept;
   logic              hit;
   logic              req_xs;
   logic              req_ys;
   logic [2*XLEN-1:0] hit_z;

   function automatic logic [XLEN-1:0] sel_half(input logic [1:0] op, input logic [2*XLEN-1:0] z);
      return (op == OP_MUL) ? z[XLEN-1:0] : z[2*XLEN-1:XLEN];
   endfunction

   assign req_xs = (bus.op == 2'b01) || (bus.op == 2'b10);
   assign req_ys = (bus.op == 2'b01);

   // rst_n gates ready so nothing is offered as accepted while reset is held
   assign bus.req_ready = rst_n && (state == IDLE) && !bus.flush;
   assign accept        = bus.req_valid && bus.req_ready;

`ifdef MUL_FUSION_EN
   logic              c_v;
   logic [XLEN-1:0]   c_x;
   logic [XLEN-1:0]   c_y;
   logic              c_xs;
   logic              c_ys;
   logic [2*XLEN-1:0] c_z;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_v  <= 1'b0;
         c_x  <= '0;
         c_y  <= '0;
         c_xs <= 1'b0;
         c_ys <= 1'b0;
         c_z  <= '0;
      end else if (state == BUSY && bus.mul_valid && !bus.flush) begin
         c_v  <= 1'b1;
         c_x  <= x_q;
         c_y  <= y_q;
         c_xs <= xs_q;
         c_ys <= ys_q;
         c_z  <= bus.mul_z;
      end
   end

   // Low half is signedness-independent, so MUL hits on any cached signedness
   assign hit   = c_v && (bus.rs1 == c_x) && (bus.rs2 == c_y) &&
                  ((bus.op == OP_MUL) || ((req_xs == c_xs) && (req_ys == c_ys)));
   assign hit_z = c_z;
`else
   assign hit   = 1'b0;
   assign hit_z = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         op_q     <= OP_MUL;
         x_q      <= '0;
         y_q      <= '0;
         tag_q    <= '0;
         xs_q     <= 1'b0;
         ys_q     <= 1'b0;
         start_q  <= 1'b0;
         result_q <= '0;
      end else begin
         start_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q  <= bus.op;
                  x_q   <= bus.rs1;
                  y_q   <= bus.rs2;
                  tag_q <= bus.rd_tag;
                  xs_q  <= req_xs;
                  ys_q  <= req_ys;
                  if (hit) begin
                     result_q <= sel_half(bus.op, hit_z);
                     state    <= DONE;
                  end else begin
                     start_q <= 1'b1;
                     state   <= BUSY;
                  end
               end
            end
            BUSY: begin
               // A flush that coincides with completion has nothing left to drain
               if (bus.flush) begin
                  state <= bus.mul_valid ? IDLE : DRAIN;
               end else if (bus.mul_valid) begin
                  result_q <= sel_half(op_q, bus.mul_z);
                  state    <= DONE;
               end
            end
            DRAIN: begin
               if (bus.mul_valid) state <= IDLE;
            end
            DONE: begin
               if (bus.flush || bus.res_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.res_valid    = (state == DONE);
   assign bus.result       = result_q;
   assign bus.res_tag      = tag_q;
   assign bus.mul_start    = start_q;
   assign bus.mul_x        = x_q;
   assign bus.mul_y        = y_q;
   assign bus.mul_x_signed = xs_q;
   assign bus.mul_y_signed = ys_q;
endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: vector table, corner sequences and random ops vs a product model.
module tb_mul_ctrl;
   localparam int XLEN = 32;
   localparam int TAGW = 5;
`ifdef MUL_FUSION_EN
   localparam bit FUSION = 1'b1;
`else
   localparam bit FUSION = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul_ctrl_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();
   mul_ctrl #(.XLEN(XLEN), .TAGW(TAGW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ext(input logic [31:0] v, input bit s);
      return s ? {{32{v[31]}}, v} : {32'b0, v};
   endfunction

   function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = ext(a, (op == 2'd1) || (op == 2'd2)) * ext(b, op == 2'd1);
      return (op == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   // reference cache of the last product that completed normally
   bit          c_v = 1'b0;
   logic [31:0] c_a, c_b;
   logic [1:0]  c_op;

   function automatic logic [1:0] sgn(input logic [1:0] op);
      return {(op == 2'd1) || (op == 2'd2), op == 2'd1};
   endfunction

   function automatic bit predict_hit(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return FUSION && c_v && (a == c_a) && (b == c_b) && ((op == 2'd0) || (sgn(op) == sgn(c_op)));
   endfunction

   task automatic note_done(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      c_v = 1'b1; c_a = a; c_b = b; c_op = op;
   endtask

   // multiplier model: product after mul_lat cycles, reset-aware
   int          mul_lat = 3;
   bit          pend = 1'b0;
   int          cnt = 0;
   logic [63:0] pz = '0;
   int          n_start = 0;
   int          n_valid = 0;
   int          valid_cyc = -10;
   bit          st_xs, st_ys;
   bit          spur_req = 1'b0;

   always @(negedge clk) begin
      bus.mul_valid = 1'b0;
      if (!rst_n) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            if (cnt == 0) begin
               bus.mul_valid = 1'b1; bus.mul_z = pz; pend = 1'b0;
               n_valid++; valid_cyc = cyc;
            end else cnt--;
         end else if (spur_req) begin
            bus.mul_valid = 1'b1; bus.mul_z = 64'hDEAD_BEEF_0BAD_F00D; spur_req = 1'b0;
         end
         if (bus.mul_start) begin
            n_start++; pend = 1'b1; cnt = mul_lat - 1;
            st_xs = bus.mul_x_signed; st_ys = bus.mul_y_signed;
            pz = ext(bus.mul_x, st_xs) * ext(bus.mul_y, st_ys);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".req_ready"}, bus.req_ready, 0);
      chk({tag, ".res_valid"}, bus.res_valid, 0);
      chk({tag, ".mul_start"}, bus.mul_start, 0);
      chk({tag, ".result"}, bus.result, 0);
      chk({tag, ".res_tag"}, bus.res_tag, 0);
      chk({tag, ".mul_xy"}, {bus.mul_x, bus.mul_y}, 0);
      chk({tag, ".signed"}, {bus.mul_x_signed, bus.mul_y_signed}, 0);
   endtask

   task automatic offer(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
      int w;
      bus.req_valid = 1'b1; bus.op = op; bus.rs1 = a; bus.rs2 = b; bus.rd_tag = tag;
      w = 0;
      while (!bus.req_ready && w < 50) begin step(); w++; end
      if (w >= 50) chk("accept_timeout", w, 0);
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int delay, input logic [31:0] exp);
      bit hit;
      int s0, w;
      hit = predict_hit(op, a, b);
      s0  = n_start;
      offer(op, a, b, tag);
      w = 1;
      while (!bus.res_valid && w < 100) begin step(); w++; end
      chk({name, ".res_valid"}, bus.res_valid, 1);
      if (hit) chk({name, ".hit_latency"}, w, 1);
      chk({name, ".starts"}, n_start - s0, hit ? 0 : 1);
      if (!hit) chk({name, ".signed"}, {st_xs, st_ys}, sgn(op));
      chk({name, ".result"}, bus.result, exp);
      chk({name, ".tag"}, bus.res_tag, tag);
      for (int i = 0; i < delay; i++) begin
         step();
         chk({name, ".hold"}, {bus.res_valid, bus.req_ready, bus.result, bus.res_tag}, {1'b1, 1'b0, exp, tag});
      end
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      chk({name, ".single_xfer"}, bus.res_valid, 0);
      if (!hit) note_done(op, a, b);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  tag;
      int          delay;
      logic [31:0] res;
   } vec_t;

   vec_t vt[7];

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int s0, v0;
      logic [31:0] a, b, pa, pb;
      logic [1:0]  op;

      vt[0] = '{2'd0, 32'd7,         32'd6,         5'd3,  5, 32'h0000_002A};
      vt[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  0, 32'h0000_0000};
      vt[2] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  1, 32'hFFFF_FFFE};
      vt[3] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 0, 32'h0000_0001};
      vt[4] = '{2'd2, 32'hFFFF_FFFF, 32'd2,         5'd4,  2, 32'hFFFF_FFFF};
      vt[5] = '{2'd2, 32'h8000_0000, 32'd3,         5'd9,  0, 32'hFFFF_FFFE};
      vt[6] = '{2'd0, 32'd3,         32'd5,         5'd7,  0, 32'd15};

      bus.req_valid = 0; bus.op = 0; bus.rs1 = 0; bus.rs2 = 0; bus.rd_tag = 0;
      bus.flush = 0; bus.res_ready = 0; bus.mul_valid = 0; bus.mul_z = '0;

      step();
      chk_reset_outputs("por");
      rst_n = 1'b1;
      step();
      chk("idle.req_ready", bus.req_ready, 1);

      foreach (vt[i]) do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].delay, vt[i].res);

      // flush four cycles after accept: drain then release
      mul_lat = 10;
      v0 = n_valid;
      offer(2'd0, 32'd9, 32'd9, 5'd5);
      repeat (3) step();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      begin
         int w;
         w = 0;
         while (!bus.req_ready && w < 40) begin
            chk("drain.no_res_valid", bus.res_valid, 0);
            step(); w++;
         end
         chk("drain.product_seen", n_valid - v0, 1);
         chk("drain.release_cycle", cyc - valid_cyc, 1);
      end
      mul_lat = 3;
      do_op("after_drain", 2'd0, 32'd3, 32'd5, 5'd6, 0, 32'd15);

      // flush in DONE wins over res_ready
      begin
         bit hit;
         hit = predict_hit(2'd0, 32'd11, 32'd13);
         offer(2'd0, 32'd11, 32'd13, 5'd8);
         repeat (20) if (!bus.res_valid) step();
         chk("flush_done.res_valid", bus.res_valid, 1);
         bus.flush = 1'b1; bus.res_ready = 1'b1;
         step();
         chk("flush_done.dropped", bus.res_valid, 0);
         bus.flush = 1'b0; bus.res_ready = 1'b0;
         #1;
         chk("flush_done.idle", bus.req_ready, 1);
         if (!hit) note_done(2'd0, 32'd11, 32'd13);
      end

      // stray mul_valid while idle
      s0 = n_start;
      spur_req = 1'b1;
      step(); step();
      chk("spurious.res_valid", bus.res_valid, 0);
      chk("spurious.req_ready", bus.req_ready, 1);

      // flush in IDLE blocks acceptance
      bus.req_valid = 1'b1; bus.op = 2'd3; bus.rs1 = 32'd4; bus.rs2 = 32'd4; bus.flush = 1'b1;
      #1;
      chk("idle_flush.req_ready", bus.req_ready, 0);
      step();
      chk("idle_flush.res_valid", bus.res_valid, 0);
      chk("idle_flush.no_start", n_start - s0, 0);
      bus.req_valid = 1'b0; bus.flush = 1'b0;
      step();

      // fusion pair: MULH then MUL on identical operands
      do_op("fuse_mulh", 2'd1, 32'h8000_0000, 32'h8000_0000, 5'd10, 0, 32'h4000_0000);
      do_op("fuse_mul",  2'd0, 32'h8000_0000, 32'h8000_0000, 5'd11, 1, 32'h0000_0000);

      // reset while busy
      mul_lat = 8;
      offer(2'd1, 32'd123, 32'd456, 5'd12);
      step();
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid_reset");
      c_v = 1'b0;
      step(); step();
      chk_reset_outputs("held_reset");
      rst_n = 1'b1;
      step();
      mul_lat = 3;
      do_op("post_reset", 2'd3, 32'd2, 32'd3, 5'd13, 0, 32'd0);

      // random ops with operand reuse to exercise the cache path
      pa = 32'd1; pb = 32'd1;
      for (int n = 0; n < 150; n++) begin
         op = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            a = pa; b = pb;
         end else begin
            a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
         end
         mul_lat = $urandom_range(1, 5);
         do_op($sformatf("rnd%0d", n), op, a, b, 5'($urandom), $urandom_range(0, 3), ref_res(op, a, b));
         pa = a; pb = b;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL take parameter XLEN, default core_config_pkg::XLEN (32), datapath width.
REQ-002 SHALL take parameter TAGW, default 5, destination-tag width.
REQ-003 clk  in  1  single clock; all state on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  request offered; req_ready  out  1  request accepted when both high.
REQ-006 op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 rs1, rs2  in  XLEN  operands; rd_tag  in  TAGW  destination tag.
REQ-008 flush  in  1  kill in-flight/held operation.
REQ-009 res_valid  out  1; res_ready  in  1; result  out  XLEN; res_tag  out  TAGW.
REQ-010 mul_start, mul_x_signed, mul_y_signed  out  1 each; mul_x, mul_y  out  XLEN  to multiplier.
REQ-011 mul_valid  in  1  multiplier done pulse; mul_z  in  2*XLEN  product.

Function
REQ-012 SHALL implement FSM IDLE, BUSY, DRAIN, DONE.
REQ-013 req_ready SHALL equal (state==IDLE && !flush).
REQ-014 On accept, SHALL register op, rs1, rs2, rd_tag; enter BUSY; assert mul_start for exactly the following cycle with mul_x=rs1, mul_y=rs2.
REQ-015 Signedness: MUL 0/0, MULH 1/1, MULHSU 1/0 (x signed, y unsigned), MULHU 0/0; held stable while BUSY/DRAIN.
REQ-016 mul_start SHALL never assert outside the cycle after acceptance; latency is not counted, completion is mul_valid only.
REQ-017 BUSY + mul_valid: capture result = mul_z[XLEN-1:0] for MUL, mul_z[2*XLEN-1:XLEN] otherwise; enter DONE; res_valid high next cycle.
REQ-018 DONE: result, res_tag stable while res_valid && !res_ready; on res_ready go IDLE next cycle.
REQ-019 flush in BUSY: go DRAIN; DRAIN waits for mul_valid, discards product, goes IDLE; no res_valid issued.
REQ-020 flush in DONE: drop result, res_valid low next cycle, IDLE; flush wins over simultaneous res_ready (result not counted as consumed).
REQ-021 flush in IDLE with req_valid: request not accepted.
REQ-022 mul_valid outside BUSY/DRAIN SHALL be ignored.

Reset
REQ-023 rst_n low SHALL force IDLE, req_ready=0 during reset, res_valid=0, mul_start=0, result=0, res_tag=0, mul_x=mul_y=0, signed flags=0, fusion cache invalid.
REQ-024 Reset mid-operation abandons operation; multiplier shares rst_n, no drain needed.

Configuration
REQ-025 Macro MUL_FUSION_EN: when defined, SHALL keep last completed (rs1, rs2, x_signed, y_signed, 2*XLEN product) plus valid bit.
REQ-026 Hit on accept: rs1/rs2 equal and (op==MUL, or signedness equal); SHALL skip mul_start, go directly DONE, res_valid the cycle after acceptance.
REQ-027 Cache updated only on REQ-017 completion; drained products not stored; flush does not invalidate.
REQ-028 Without MUL_FUSION_EN: no cache storage, every request issues mul_start.

Verification
REQ-029 MUL rs1=7, rs2=6, tag=3 -> one mul_start, result=0x0000002A, res_tag=3.
REQ-030 rs1=rs2=0xFFFFFFFF: MULH -> 0x00000000; MULHU -> 0xFFFFFFFE; MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
REQ-031 res_ready low 5 cycles after res_valid -> result/res_tag constant, req_ready=0, then single transfer.
REQ-032 flush 4 cycles after accept -> DRAIN, no res_valid, req_ready=0 until cycle after mul_valid; next MUL 3*5 -> 15.
REQ-033 MUL_FUSION_EN: MULH 0x80000000*0x80000000 -> 0x40000000; then MUL same operands -> 0x00000000, no mul_start, res_valid cycle after accept; without macro mul_start issued.
REQ-034 rst_n low while BUSY -> all outputs at REQ-023 values; MULHU 2*3 after release -> 0x00000000.
